conv_pool_seq: RTL and testbench
================================

// Module: conv_pool_seq
// PURPOSE
//  Job sequencer for one conv_pool datapath instance. Holds NUM_BANKS kernel/shift sets written over a config port.
//  On start, it latches one bank onto the datapath and streams cp_input_re/cp_input_addr over a contiguous block range.
//  It counts the datapath's per-channel result writes, waits for the pipeline to drain, then pulses done with error status.
//  Sits between the host/config logic and conv_pool; the image and result memories stay outside.
// PARAMETERS
//  ADDR_W         16   image/result block address width
//  NUM_BANKS       4   kernel sets stored (3 kernels + shift each); BANK_W = max(1,$clog2(NUM_BANKS))
//  DRAIN_TIMEOUT  64   max cycles in DRAIN with no cp_output_we_* before abandoning job
// PORTS
//  clk            in   1       clock; all logic on rising edge
//  rst            in   1       synchronous, active-high reset
//  cfg_we         in   1       write cfg_data into bank cfg_bank, field cfg_sel
//  cfg_bank       in   BANK_W  target bank
//  cfg_sel        in   2       0/1/2 = kernel 0/1/2, 3 = shift (cfg_data[1:0])
//  cfg_data       in   72      signed 9x8 kernel, same packing as conv_pool conv_kernel_*
//  start          in   1       job request, honoured only in IDLE
//  start_bank     in   BANK_W  bank for job
//  start_base     in   ADDR_W  first image block address
//  start_len      in   ADDR_W+1  number of blocks, 0..2^ADDR_W
//  abort          in   1       terminate running job
//  busy           out  1       high in RUN/DRAIN/DONE
//  done           out  1       1-cycle pulse at job end
//  err            out  3       [0] drain timeout, [1] result overrun, [2] aborted; held until next accepted start
//  cp_rst         out  1       to conv_pool rst: 1 = run, 0 = held in reset (0 in IDLE/DONE)
//  cp_kernel_0/1/2 out 72 each latched kernels of active bank
//  cp_shift       out  2       latched shift of active bank
//  cp_input_re    out  1       image read enable to conv_pool/memory
//  cp_input_addr  out  ADDR_W  image block address
//  cp_output_we_0/1/2 in 1 each  conv_pool result write strobes (monitored only)
// BEHAVIOUR
//  - All outputs registered. rst: state IDLE, all outputs 0, all bank contents 0, counters 0.
//  - cfg writes are accepted in any state. cp_kernel_*/cp_shift are copies latched at start.
//    A cfg write never alters the running job. Same-edge cfg_we + start on the same bank: the job gets the OLD value.
//  - States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 with start_len!=0 at edge E: latch bank/base/len, clear err and counters, go RUN.
//    From E+1: cp_rst=1, cp_input_re=1, cp_input_addr=base.
//  - IDLE: start=1 with start_len==0: go DONE directly, with no reads and err=0.
//  - start is ignored outside IDLE.
//  - RUN: one read per cycle, addr = base+k mod 2^ADDR_W (wraps FFFF->0000), k=0..len-1.
//    After exactly len cycles with cp_input_re=1, go DRAIN. cp_input_re=0 from the next cycle.
//  - Result counters res_c (ADDR_W+1 bits) increment on cp_output_we_c during RUN and DRAIN.
//    If a strobe arrives with res_c==len: set err[1], count saturates, job continues.
//  - DRAIN: when res_0==res_1==res_2==len -> DONE.
//    Idle counter resets on any cp_output_we_*. Reaching DRAIN_TIMEOUT -> set err[0], go DONE.
//  - abort in RUN or DRAIN: go DONE at that edge, set err[2]. cp_input_re=0 from the next cycle.
//    abort in IDLE/DONE is ignored. abort beats completion on the same edge.
//  - DONE: single cycle; done=1, cp_rst=0 (datapath pipeline flushed), then IDLE. busy falls with it.
//  - rst mid-job: everything returns to reset values at that edge. No done pulse.
// TESTING
//  1 cfg bank1 k0=72'h01..09, shift=2; start bank1 base=0x0010 len=4; model gives 4 we/ch
//    -> re high exactly 4 cycles, addr 10..13, cp_kernel_0 = bank1 value, done pulse, err=0.
//  2 base=0xFFFE len=4 -> addrs FFFE,FFFF,0000,0001; done after 4 writes/ch.
//  3 len=3, ch2 model emits only 2 writes -> done exactly DRAIN_TIMEOUT cycles after last we, err=3'b001.
//  4 during RUN: start pulse and cfg write to active bank -> no effect on addr/kernels; next job uses new value.
//  5 abort on 3rd RUN cycle -> re low next cycle, done next, err=3'b100, cp_rst=0; start with len=0 -> done, no reads.
//  6 rst mid-RUN -> all outputs 0 next cycle, no done, banks read back 0 on a following job.

Source files
------------

// File: rtl/conv_pool_seq.sv
// conv_pool_seq: job sequencer for one conv_pool datapath.
//   Holds NUM_BANKS kernel/shift sets written over a config port. A start
//   latches one bank onto the datapath and streams image reads over a
//   contiguous block range. It then counts per-channel result writes, waits
//   for the pipeline to drain and pulses done with an error status.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cfg_we_i/bank_i/sel_i/data_i  bank write (sel 0..2 kernel, 3 shift)
//   start_i/bank_i/base_i/len_i   job request, honoured only in IDLE
//   abort_i                       terminate a running job
//   busy_o, done_o, err_o         status: err = {aborted, overrun, timeout}
//   cp_rst_o                      datapath run (1) / held in reset (0)
//   cp_kernel_0/1/2_o, cp_shift_o latched kernels/shift of the active bank
//   cp_input_re_o, cp_input_addr_o image read stream
//   cp_output_we_0/1/2_i          datapath result write strobes (monitored)
module conv_pool_seq #(
  parameter int ADDR_W        = 16,
  parameter int NUM_BANKS     = 4,
  parameter int DRAIN_TIMEOUT = 64,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [BANK_W-1:0] cfg_bank_i,
  input  logic [1:0]        cfg_sel_i,
  input  logic [71:0]       cfg_data_i,
  input  logic              start_i,
  input  logic [BANK_W-1:0] start_bank_i,
  input  logic [ADDR_W-1:0] start_base_i,
  input  logic [ADDR_W:0]   start_len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        err_o,
  output logic              cp_rst_o,
  output logic [71:0]       cp_kernel_0_o,
  output logic [71:0]       cp_kernel_1_o,
  output logic [71:0]       cp_kernel_2_o,
  output logic [1:0]        cp_shift_o,
  output logic              cp_input_re_o,
  output logic [ADDR_W-1:0] cp_input_addr_o,
  input  logic              cp_output_we_0_i,
  input  logic              cp_output_we_1_i,
  input  logic              cp_output_we_2_i
);

  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e state_q, state_d;

  logic [2:0][71:0]  bank_kern_q [NUM_BANKS];
  logic [1:0]        bank_shift_q [NUM_BANKS];
  logic [2:0][71:0]  kern_q;
  logic [1:0]        shift_q;
  logic [ADDR_W:0]   len_q, rem_q;
  logic [2:0][ADDR_W:0] res_q;
  logic [IDLE_W-1:0] idle_q;
  logic [2:0]        err_q;
  logic [ADDR_W-1:0] addr_q;
  logic busy_q, busy_d, done_q, done_d, cprst_q, cprst_d, re_q, re_d;

  logic [2:0] we;
  logic accept, counting, all_done, tmo;

  assign we       = {cp_output_we_2_i, cp_output_we_1_i, cp_output_we_0_i};
  assign accept   = (state_q == S_IDLE) && start_i;
  assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign all_done = (res_q[0] == len_q) && (res_q[1] == len_q) && (res_q[2] == len_q);
  // Fires on the DRAIN_TIMEOUT-th consecutive strobe-free DRAIN edge.
  assign tmo      = (state_q == S_DRAIN) && (we == 3'b000) && (idle_q == IDLE_LAST);

  // State register; the status outputs are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cprst_q <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cprst_q <= cprst_d;
      re_q    <= re_d;
    end
  end

  // Next state. Abort has priority over completion and timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (start_len_i == '0) ? S_DONE : S_RUN;
      S_RUN:   if (abort_i) state_d = S_DONE;
               else if (rem_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
      S_DRAIN: if (abort_i || all_done || tmo) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode (registered above).
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    cprst_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    re_d    = (state_d == S_RUN);
  end

  // Banks, job registers, counters and error status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_kern_q[b]  <= '0;
        bank_shift_q[b] <= '0;
      end
      kern_q  <= '0;
      shift_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      res_q   <= '0;
      idle_q  <= '0;
      err_q   <= '0;
    end else begin
      // Banks are read before this write lands, so a same-edge start sees
      // the old contents.
      if (cfg_we_i) begin
        if (cfg_sel_i == 2'd3) bank_shift_q[cfg_bank_i] <= cfg_data_i[1:0];
        else                   bank_kern_q[cfg_bank_i][cfg_sel_i] <= cfg_data_i;
      end
      if (accept) begin
        kern_q  <= bank_kern_q[start_bank_i];
        shift_q <= bank_shift_q[start_bank_i];
        len_q   <= start_len_i;
        rem_q   <= start_len_i;
        addr_q  <= start_base_i;
        res_q   <= '0;
        idle_q  <= '0;
        err_q   <= '0;
      end else begin
        if (state_q == S_RUN) rem_q <= rem_q - (ADDR_W+1)'(1);
        // Address wraps naturally at 2^ADDR_W.
        if (state_q == S_RUN && state_d == S_RUN) addr_q <= addr_q + ADDR_W'(1);
        for (int c = 0; c < 3; c++) begin
          if (counting && we[c]) begin
            if (res_q[c] == len_q) err_q[1] <= 1'b1;  // saturate, keep going
            else                   res_q[c] <= res_q[c] + (ADDR_W+1)'(1);
          end
        end
        if (we != 3'b000)            idle_q <= '0;
        else if (state_q == S_DRAIN) idle_q <= idle_q + IDLE_W'(1);
        if (tmo && !all_done && !abort_i) err_q[0] <= 1'b1;
        if (counting && abort_i)          err_q[2] <= 1'b1;
      end
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign cp_rst_o        = cprst_q;
  assign cp_kernel_0_o   = kern_q[0];
  assign cp_kernel_1_o   = kern_q[1];
  assign cp_kernel_2_o   = kern_q[2];
  assign cp_shift_o      = shift_q;
  assign cp_input_re_o   = re_q;
  assign cp_input_addr_o = addr_q;

endmodule

// File: tb/tb_conv_pool_seq.sv
// Self-checking bench for conv_pool_seq. A behavioural datapath stand-in
// answers every observed read with one result write per channel after a
// fixed latency (optionally capped per channel); expected addresses,
// kernels and status come from the job description and a bank store model.
module tb_conv_pool_seq;
  localparam int AW = 16, NB = 4, TO = 64, BW = 2, LAT = 3, BUDGET = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [BW-1:0] cfg_bank = '0;
  logic [1:0]    cfg_sel = '0;
  logic [71:0]   cfg_data = '0;
  logic          start = 1'b0;
  logic [BW-1:0] start_bank = '0;
  logic [AW-1:0] start_base = '0;
  logic [AW:0]   start_len = '0;
  logic          abort = 1'b0;
  logic          busy, done, cp_rst, re;
  logic [2:0]    err;
  logic [71:0]   k0, k1, k2;
  logic [1:0]    shift;
  logic [AW-1:0] addr;
  logic          we0 = 1'b0, we1 = 1'b0, we2 = 1'b0;

  conv_pool_seq #(.ADDR_W(AW), .NUM_BANKS(NB), .DRAIN_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_we_i(cfg_we), .cfg_bank_i(cfg_bank), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data),
    .start_i(start), .start_bank_i(start_bank), .start_base_i(start_base), .start_len_i(start_len),
    .abort_i(abort), .busy_o(busy), .done_o(done), .err_o(err), .cp_rst_o(cp_rst),
    .cp_kernel_0_o(k0), .cp_kernel_1_o(k1), .cp_kernel_2_o(k2), .cp_shift_o(shift),
    .cp_input_re_o(re), .cp_input_addr_o(addr),
    .cp_output_we_0_i(we0), .cp_output_we_1_i(we1), .cp_output_we_2_i(we2)
  );

  int n_cmp = 0, n_bad = 0;

  // Bank store model
  logic [71:0] m_kern [NB][3];
  logic [1:0]  m_shift [NB];

  // Observations of the last job
  logic [AW-1:0] obs_addr[$];
  int          done_seen, done_cyc, last_we_cyc;
  logic [2:0]  err_done;
  logic [71:0] kf [3];
  logic [71:0] k0_done;
  logic [1:0]  sh_first;
  logic        rst_first, cprst_done, busy_done, done_after, busy_after;

  function automatic logic [71:0] rnd72();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  task automatic cfg_write(input int b, input int s, input logic [71:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_bank = b[BW-1:0]; cfg_sel = s[1:0]; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (s == 3) m_shift[b] = d[1:0]; else m_kern[b][s] = d;
  endtask

  // Drives one job and plays the datapath. poke_at injects a start pulse plus
  // a kernel-0 write to the active bank; extra0 adds one early ch0 write.
  task automatic run_job(input int b, input logic [AW-1:0] base, input int len,
                         input int cap0, input int cap1, input int cap2,
                         input int abort_at, input int poke_at,
                         input logic [71:0] poke_d, input bit extra0);
    bit [2:0] wemap [512];
    int cap [3];
    int issued [3];
    int cyc;
    cap[0] = cap0; cap[1] = cap1; cap[2] = cap2;
    for (int i = 0; i < 3; i++) issued[i] = 0;
    for (int i = 0; i < 512; i++) wemap[i] = 3'b000;
    obs_addr.delete();
    done_seen = 0; done_cyc = -1; last_we_cyc = -1;
    @(negedge clk);
    start = 1'b1; start_bank = b[BW-1:0]; start_base = base; start_len = len[AW:0];
    cyc = 0;
    while (cyc < BUDGET && done_seen == 0) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0; abort = 1'b0;
      if (cyc == 1) begin
        kf[0] = k0; kf[1] = k1; kf[2] = k2; sh_first = shift; rst_first = cp_rst;
        if (extra0) wemap[2][0] = 1'b1;
      end
      if (re) begin
        obs_addr.push_back(addr);
        for (int c = 0; c < 3; c++)
          if (issued[c] < cap[c]) begin wemap[cyc+LAT][c] = 1'b1; issued[c]++; end
      end
      if (done) begin
        done_seen = 1; done_cyc = cyc; err_done = err;
        cprst_done = cp_rst; busy_done = busy; k0_done = k0;
        {we2, we1, we0} = 3'b000;
      end else begin
        {we2, we1, we0} = wemap[cyc];
        if (wemap[cyc] != 3'b000) last_we_cyc = cyc;
        if (cyc == abort_at) abort = 1'b1;
        if (cyc == poke_at) begin
          start = 1'b1; start_base = 16'hAAAA;
          cfg_we = 1'b1; cfg_bank = b[BW-1:0]; cfg_sel = 2'd0; cfg_data = poke_d;
        end
      end
    end
    {we2, we1, we0} = 3'b000; abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    done_after = done; busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, cp_rst, re} !== 7'b0 || addr !== '0 || k0 !== '0 || k1 !== '0 ||
        k2 !== '0 || shift !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b cp_rst=%b re=%b addr=%h shift=%b, want all 0",
               busy, done, err, cp_rst, re, addr, shift);
    end
    rst = 1'b0;
    for (int b = 0; b < NB; b++) begin
      m_shift[b] = '0;
      for (int s = 0; s < 3; s++) m_kern[b][s] = '0;
    end
  endtask

  task automatic test_basic();
    cfg_write(1, 0, 72'h010203040506070809);
    cfg_write(1, 1, rnd72());
    cfg_write(1, 2, rnd72());
    cfg_write(1, 3, 72'd2);
    run_job(1, 16'h0010, 4, 4, 4, 4, -1, -1, '0, 1'b0);
    n_cmp++;
    if (obs_addr.size() !== 4) begin n_bad++; $display("FAIL basic_nreads: got %0d want 4", obs_addr.size()); end
    for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
      n_cmp++;
      if (obs_addr[k] !== 16'(16'h0010 + k)) begin
        n_bad++; $display("FAIL basic_addr%0d: got %h want %h", k, obs_addr[k], 16'(16'h0010 + k));
      end
    end
    n_cmp++;
    if (kf[0] !== 72'h010203040506070809 || kf[1] !== m_kern[1][1] || kf[2] !== m_kern[1][2] ||
        sh_first !== 2'd2) begin
      n_bad++; $display("FAIL basic_kernels: got k0=%h shift=%0d want k0=%h shift=2", kf[0], sh_first, m_kern[1][0]);
    end
    n_cmp++;
    if (rst_first !== 1'b1) begin n_bad++; $display("FAIL basic_cp_rst_run: got %b want 1", rst_first); end
    n_cmp++;
    if (done_seen !== 1 || err_done !== 3'b000 || cprst_done !== 1'b0 || busy_done !== 1'b1) begin
      n_bad++; $display("FAIL basic_done: got seen=%0d err=%b cp_rst=%b busy=%b want 1 000 0 1",
                        done_seen, err_done, cprst_done, busy_done);
    end
    n_cmp++;
    if (done_after !== 1'b0 || busy_after !== 1'b0) begin
      n_bad++; $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done_after, busy_after);
    end
  endtask

  task automatic test_wrap();
    run_job(1, 16'hFFFE, 4, 4, 4, 4, -1, -1, '0, 1'b0);
    n_cmp++;
    if (obs_addr.size() !== 4) begin n_bad++; $display("FAIL wrap_nreads: got %0d want 4", obs_addr.size()); end
    for (int k = 0; k < obs_addr.size() && k < 4; k++) begin
      n_cmp++;
      if (obs_addr[k] !== 16'(32'hFFFE + k)) begin
        n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", k, obs_addr[k], 16'(32'hFFFE + k));
      end
    end
    n_cmp++;
    if (done_seen !== 1 || err_done !== 3'b000 || done_cyc <= last_we_cyc) begin
      n_bad++; $display("FAIL wrap_done: got seen=%0d err=%b done_cyc=%0d last_we=%0d", done_seen, err_done,
                        done_cyc, last_we_cyc);
    end
  endtask

  task automatic test_timeout();
    run_job(0, 16'h0200, 3, 3, 3, 2, -1, -1, '0, 1'b0);
    n_cmp++;
    if (done_seen !== 1 || err_done !== 3'b001) begin
      n_bad++; $display("FAIL timeout_err: got seen=%0d err=%b want 1 001", done_seen, err_done);
    end
    // edge that sampled the last strobe -> edge that registered done
    n_cmp++;
    if (done_cyc - last_we_cyc - 1 !== TO) begin
      n_bad++; $display("FAIL timeout_latency: got %0d edges want %0d", done_cyc - last_we_cyc - 1, TO);
    end
  endtask

  task automatic test_overrun();
    run_job(0, 16'h0300, 4, 4, 4, 4, -1, -1, '0, 1'b1);
    n_cmp++;
    if (done_seen !== 1 || err_done !== 3'b010) begin
      n_bad++; $display("FAIL overrun_err: got seen=%0d err=%b want 1 010", done_seen, err_done);
    end
  endtask

  task automatic test_ignore_start_cfg();
    logic [71:0] old_k, new_k;
    logic [AW-1:0] base;
    cfg_write(2, 0, rnd72());
    old_k = m_kern[2][0];
    new_k = ~old_k;
    base = 16'($urandom);
    run_job(2, base, 6, 6, 6, 6, -1, 3, new_k, 1'b0);
    n_cmp++;
    if (obs_addr.size() !== 6) begin n_bad++; $display("FAIL poke_nreads: got %0d want 6", obs_addr.size()); end
    for (int k = 0; k < obs_addr.size() && k < 6; k++) begin
      n_cmp++;
      if (obs_addr[k] !== 16'(base + k)) begin
        n_bad++; $display("FAIL poke_addr%0d: got %h want %h", k, obs_addr[k], 16'(base + k));
      end
    end
    n_cmp++;
    if (kf[0] !== old_k || k0_done !== old_k || err_done !== 3'b000) begin
      n_bad++; $display("FAIL poke_kernel_held: got first=%h at_done=%h err=%b want %h 000",
                        kf[0], k0_done, err_done, old_k);
    end
    m_kern[2][0] = new_k;
    run_job(2, 16'h0000, 2, 2, 2, 2, -1, -1, '0, 1'b0);
    n_cmp++;
    if (kf[0] !== m_kern[2][0]) begin
      n_bad++; $display("FAIL poke_next_job: got %h want %h", kf[0], m_kern[2][0]);
    end
  endtask

  task automatic test_abort_zero();
    run_job(3, 16'h0400, 6, 6, 6, 6, 3, -1, '0, 1'b0);
    n_cmp++;
    if (obs_addr.size() !== 3 || done_cyc !== 4) begin
      n_bad++; $display("FAIL abort_timing: got reads=%0d done_cyc=%0d want 3 4", obs_addr.size(), done_cyc);
    end
    n_cmp++;
    if (err_done !== 3'b100 || cprst_done !== 1'b0) begin
      n_bad++; $display("FAIL abort_status: got err=%b cp_rst=%b want 100 0", err_done, cprst_done);
    end
    run_job(3, 16'h0500, 0, 0, 0, 0, -1, -1, '0, 1'b0);
    n_cmp++;
    if (obs_addr.size() !== 0 || done_cyc !== 1 || err_done !== 3'b000) begin
      n_bad++; $display("FAIL zero_len: got reads=%0d done_cyc=%0d err=%b want 0 1 000",
                        obs_addr.size(), done_cyc, err_done);
    end
  endtask

  task automatic test_same_edge();
    logic [71:0] old_k, new_k;
    old_k = m_kern[3][1];
    new_k = rnd72();
    @(negedge clk);
    start = 1'b1; start_bank = 2'd3; start_base = 16'h0600; start_len = 17'd1;
    cfg_we = 1'b1; cfg_bank = 2'd3; cfg_sel = 2'd1; cfg_data = new_k;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0; abort = 1'b1;
    m_kern[3][1] = new_k;
    n_cmp++;
    if (k1 !== old_k) begin n_bad++; $display("FAIL same_edge_old: got %h want %h", k1, old_k); end
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || err !== 3'b100) begin
      n_bad++; $display("FAIL same_edge_abort: got done=%b err=%b want 1 100", done, err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int hits;
    @(negedge clk);
    start = 1'b1; start_bank = 2'd1; start_base = 16'h0100; start_len = 17'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (re !== 1'b1) begin n_bad++; $display("FAIL rstmid_running: got re=%b want 1", re); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, err, cp_rst, re} !== 7'b0 || addr !== '0 || k0 !== '0 || k1 !== '0 ||
        k2 !== '0 || shift !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got busy=%b done=%b err=%b cp_rst=%b re=%b addr=%h, want all 0",
                        busy, done, err, cp_rst, re, addr);
    end
    rst = 1'b0;
    for (int b = 0; b < NB; b++) begin
      m_shift[b] = '0;
      for (int s = 0; s < 3; s++) m_kern[b][s] = '0;
    end
    hits = 0;
    repeat (20) begin @(negedge clk); if (done || re) hits++; end
    n_cmp++;
    if (hits !== 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", hits); end
    run_job(1, 16'h0000, 2, 2, 2, 2, -1, -1, '0, 1'b0);
    n_cmp++;
    if (kf[0] !== m_kern[1][0] || kf[1] !== m_kern[1][1] || kf[2] !== m_kern[1][2] || sh_first !== m_shift[1]) begin
      n_bad++; $display("FAIL rstmid_banks: got k0=%h k1=%h k2=%h shift=%0d want cleared", kf[0], kf[1], kf[2], sh_first);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      int b, len;
      logic [AW-1:0] base;
      b = $urandom_range(0, NB-1);
      for (int s = 0; s < 3; s++) cfg_write(b, s, rnd72());
      cfg_write(b, 3, rnd72());
      base = (j % 2 == 1) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      len  = $urandom_range(1, 10);
      run_job(b, base, len, len, len, len, -1, -1, '0, 1'b0);
      n_cmp++;
      if (obs_addr.size() !== len) begin
        n_bad++; $display("FAIL rand%0d_nreads: got %0d want %0d", j, obs_addr.size(), len);
      end
      for (int k = 0; k < obs_addr.size() && k < len; k++) begin
        n_cmp++;
        if (obs_addr[k] !== 16'(base + k)) begin
          n_bad++; $display("FAIL rand%0d_addr%0d: got %h want %h", j, k, obs_addr[k], 16'(base + k));
        end
      end
      n_cmp++;
      if (kf[0] !== m_kern[b][0] || kf[1] !== m_kern[b][1] || kf[2] !== m_kern[b][2] || sh_first !== m_shift[b]) begin
        n_bad++; $display("FAIL rand%0d_kernels: bank %0d k0=%h want %h shift=%0d want %0d",
                          j, b, kf[0], m_kern[b][0], sh_first, m_shift[b]);
      end
      n_cmp++;
      if (done_seen !== 1 || err_done !== 3'b000) begin
        n_bad++; $display("FAIL rand%0d_done: got seen=%0d err=%b want 1 000", j, done_seen, err_done);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_overrun();
    test_ignore_start_cfg();
    test_abort_zero();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
